// File: rtl/rename_fl_pkg.sv
// Shared types and sizing for the register renamer and its free list.
package rename_fl_pkg;

  localparam int ARFSIZE      = 32;
  localparam int PRFSIZE      = 64;
  localparam int ARF_ID_BITS  = $clog2(ARFSIZE);
  localparam int PREG_ID_BITS = $clog2(PRFSIZE);
  // One extra pointer bit tells a full free list apart from an empty one
  localparam int FL_PTR_BITS  = PREG_ID_BITS + 1;
  localparam int RENAME_WIDTH = 2;
  localparam int RETIRE_WIDTH = 2;

  typedef logic [ARF_ID_BITS-1:0]  arf_id_t;
  typedef logic [PREG_ID_BITS-1:0] preg_id_t;
  typedef logic [FL_PTR_BITS-1:0]  fl_ptr_t;

  typedef struct packed {
    arf_id_t  rs1;
    arf_id_t  rs2;
    arf_id_t  rd;
    logic     rd_valid;
    preg_id_t prs1;
    preg_id_t prs2;
    preg_id_t prd;
    preg_id_t prd_old;
    logic     prs1_renammed;
    logic     prs2_renammed;
  } di_t;

  typedef struct packed {
    arf_id_t  ard;
    preg_id_t prd;
    preg_id_t prd_old;
    logic     needprf2arf;
  } rob_entry_t;

endpackage

// File: rtl/squash_if.sv
// Pipeline-wide squash request; the renamer only listens.
interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/rename_freelist.sv
// Circular FIFO of free physical registers. Rename pops from head, retire
// pushes freed pregs at tail, and commit_head tracks the head as seen by
// retired instructions so a squash can rewind head exactly.
import rename_fl_pkg::*;

module rename_freelist #(
  parameter int WIDTH   = RENAME_WIDTH,
  parameter int RWIDTH  = RETIRE_WIDTH,
  parameter int ARFSIZE = rename_fl_pkg::ARFSIZE,
  parameter int PRFSIZE = rename_fl_pkg::PRFSIZE
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  fl_ptr_t                 pop_cnt,
  input  logic     [RWIDTH-1:0]   push_valid,
  input  preg_id_t [RWIDTH-1:0]   push_preg,
  input  logic                    squash,
  output preg_id_t [WIDTH-1:0]    head_pregs,
  output fl_ptr_t                 free_cnt
);

  localparam fl_ptr_t FL_CAP = fl_ptr_t'(PRFSIZE - ARFSIZE);

  preg_id_t mem [PRFSIZE];
  fl_ptr_t  head;
  fl_ptr_t  tail;
  fl_ptr_t  commit_head;
  fl_ptr_t  push_off [RWIDTH];
  fl_ptr_t  push_cnt;
  fl_ptr_t  head_next;
  fl_ptr_t  tail_next;
  fl_ptr_t  commit_head_next;

  // Pack the valid retire pushes densely, oldest slot first
  always_comb begin
    push_cnt = '0;
    for (int r = 0; r < RWIDTH; r++) begin
      push_off[r] = push_cnt;
      if (push_valid[r]) push_cnt = push_cnt + fl_ptr_t'(1);
    end
  end

  // Next pointers; a squash rewinds head to the post-retire commit_head
  always_comb begin
    tail_next        = tail + push_cnt;
    commit_head_next = commit_head + push_cnt;
    head_next        = squash ? commit_head_next : head + pop_cnt;
  end

  // Expose the next WIDTH candidate pregs starting at head
  always_comb begin
    head_pregs = '0;
    for (int k = 0; k < WIDTH; k++) begin
      head_pregs[k] = mem[preg_id_t'(head + fl_ptr_t'(k))];
    end
  end

  assign free_cnt = tail - head;

  // Free list storage and pointers; reset loads ARFSIZE..PRFSIZE-1 in order
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < PRFSIZE; i++) begin
        mem[i] <= (i < PRFSIZE - ARFSIZE) ? preg_id_t'(i + ARFSIZE) : '0;
      end
      head        <= '0;
      commit_head <= '0;
      tail        <= FL_CAP;
    end else begin
      for (int r = 0; r < RWIDTH; r++) begin
        if (push_valid[r]) mem[preg_id_t'(tail + push_off[r])] <= push_preg[r];
      end
      head        <= head_next;
      tail        <= tail_next;
      commit_head <= commit_head_next;
    end
  end

  // Catch free-list overflow and retires with nothing outstanding
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (fl_ptr_t'(tail_next - head_next) <= FL_CAP);
      if (push_cnt != '0) assert (commit_head != head);
    end
  end

endmodule

// File: rtl/rename_fl.sv
// N-wide register renamer: speculative and committed RMTs plus a circular
// free list. Renames a whole group or nothing, bypasses destinations to
// younger sources in the same group, and rewinds to committed state on squash.
import rename_fl_pkg::*;

module rename_fl #(
  parameter int WIDTH   = RENAME_WIDTH,
  parameter int RWIDTH  = RETIRE_WIDTH,
  parameter int ARFSIZE = rename_fl_pkg::ARFSIZE,
  parameter int PRFSIZE = rename_fl_pkg::PRFSIZE
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  di_t        [WIDTH-1:0]    di_i,
  input  logic       [WIDTH-1:0]    di_i_valid,
  output logic                      di_i_ready,
  output di_t        [WIDTH-1:0]    di_o,
  output logic       [WIDTH-1:0]    di_o_valid,
  input  logic                      di_o_ready,
  input  rob_entry_t [RWIDTH-1:0]   retire_entry_i,
  input  logic       [RWIDTH-1:0]   retire_entry_i_valid,
  squash_if.slave                   squash_io
);

  preg_id_t spec_rmt        [ARFSIZE];
  preg_id_t commit_rmt      [ARFSIZE];
  preg_id_t commit_rmt_next [ARFSIZE];

  logic     [WIDTH-1:0]  need_alloc;
  preg_id_t [WIDTH-1:0]  alloc_prd;
  preg_id_t [WIDTH-1:0]  fl_pregs;
  fl_ptr_t               need;
  fl_ptr_t               free_cnt;
  fl_ptr_t               pop_cnt;
  logic     [RWIDTH-1:0] push_valid;
  preg_id_t [RWIDTH-1:0] push_preg;
  logic                  squash;

  assign squash     = squash_io.valid;
  assign di_i_ready = rstn && di_o_ready && !squash && (need <= free_cnt);
  assign di_o_valid = di_i_valid & {WIDTH{di_i_ready}};
  assign pop_cnt    = di_i_ready ? need : '0;

  // Hand the k-th allocating slot the k-th preg from the free-list head
  always_comb begin
    need       = '0;
    need_alloc = '0;
    alloc_prd  = '0;
    for (int s = 0; s < WIDTH; s++) begin
      need_alloc[s] = di_i_valid[s] && di_i[s].rd_valid && (di_i[s].rd != '0);
      if (need_alloc[s]) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (fl_ptr_t'(k) == need) alloc_prd[s] = fl_pregs[k];
        end
        need = need + fl_ptr_t'(1);
      end
    end
  end

  // Source and old-destination lookup; the youngest older slot writing the
  // same register overrides the RMT, and x0 always reads preg 0
  always_comb begin
    di_o = di_i;
    for (int s = 0; s < WIDTH; s++) begin
      di_o[s].prs1    = (di_i[s].rs1 == '0) ? '0 : spec_rmt[di_i[s].rs1];
      di_o[s].prs2    = (di_i[s].rs2 == '0) ? '0 : spec_rmt[di_i[s].rs2];
      di_o[s].prd_old = (di_i[s].rd  == '0) ? '0 : spec_rmt[di_i[s].rd];
      for (int j = 0; j < s; j++) begin
        if (need_alloc[j]) begin
          if (di_i[j].rd == di_i[s].rs1) di_o[s].prs1    = alloc_prd[j];
          if (di_i[j].rd == di_i[s].rs2) di_o[s].prs2    = alloc_prd[j];
          if (di_i[j].rd == di_i[s].rd)  di_o[s].prd_old = alloc_prd[j];
        end
      end
      di_o[s].prd           = alloc_prd[s];
      di_o[s].prs1_renammed = 1'b1;
      di_o[s].prs2_renammed = 1'b1;
    end
  end

  // Apply retires in slot order to the committed map and queue freed pregs
  always_comb begin
    push_valid = '0;
    push_preg  = '0;
    for (int i = 0; i < ARFSIZE; i++) commit_rmt_next[i] = commit_rmt[i];
    for (int r = 0; r < RWIDTH; r++) begin
      if (retire_entry_i_valid[r] && retire_entry_i[r].needprf2arf) begin
        commit_rmt_next[retire_entry_i[r].ard] = retire_entry_i[r].prd;
        push_valid[r] = 1'b1;
        push_preg[r]  = retire_entry_i[r].prd_old;
      end
    end
  end

  // RMT state: identity at reset, squash copies the post-retire committed map
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ARFSIZE; i++) begin
        spec_rmt[i]   <= preg_id_t'(i);
        commit_rmt[i] <= preg_id_t'(i);
      end
    end else begin
      for (int i = 0; i < ARFSIZE; i++) commit_rmt[i] <= commit_rmt_next[i];
      if (squash) begin
        for (int i = 0; i < ARFSIZE; i++) spec_rmt[i] <= commit_rmt_next[i];
      end else if (di_i_ready) begin
        for (int s = 0; s < WIDTH; s++) begin
          if (need_alloc[s]) spec_rmt[di_i[s].rd] <= alloc_prd[s];
        end
      end
    end
  end

  rename_freelist #(
    .WIDTH   (WIDTH),
    .RWIDTH  (RWIDTH),
    .ARFSIZE (ARFSIZE),
    .PRFSIZE (PRFSIZE)
  ) u_freelist (
    .clk        (clk),
    .rstn       (rstn),
    .pop_cnt    (pop_cnt),
    .push_valid (push_valid),
    .push_preg  (push_preg),
    .squash     (squash),
    .head_pregs (fl_pregs),
    .free_cnt   (free_cnt)
  );

endmodule

// File: tb/tb_rename_fl.sv
// Self-checking bench for rename_fl: a sequential rename model built on
// queues checks every cycle, with directed scenarios pinning key values.
import rename_fl_pkg::*;

module tb_rename_fl;

  logic                          clk;
  logic                          rstn;
  di_t        [RENAME_WIDTH-1:0] di_i;
  logic       [RENAME_WIDTH-1:0] di_i_valid;
  logic                          di_i_ready;
  di_t        [RENAME_WIDTH-1:0] di_o;
  logic       [RENAME_WIDTH-1:0] di_o_valid;
  logic                          di_o_ready;
  rob_entry_t [RETIRE_WIDTH-1:0] retire_entry_i;
  logic       [RETIRE_WIDTH-1:0] retire_entry_i_valid;

  squash_if sq ();

  int pass_count  = 0;
  int check_count = 0;

  // Model state: free pregs in order, pregs handed out but not yet retired,
  // and the two architectural-to-physical maps
  int fq[$];
  int inflight[$];
  int spec_map[32];
  int commit_map[32];

  rename_fl dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .di_i                 (di_i),
    .di_i_valid           (di_i_valid),
    .di_i_ready           (di_i_ready),
    .di_o                 (di_o),
    .di_o_valid           (di_o_valid),
    .di_o_ready           (di_o_ready),
    .retire_entry_i       (retire_entry_i),
    .retire_entry_i_valid (retire_entry_i_valid),
    .squash_io            (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic di_t mk(input int rd, input int rs1, input int rs2, input bit rdv);
    di_t d = '0;
    d.rd       = arf_id_t'(rd);
    d.rs1      = arf_id_t'(rs1);
    d.rs2      = arf_id_t'(rs2);
    d.rd_valid = rdv;
    return d;
  endfunction

  function automatic rob_entry_t mkr(input int ard, input int prd, input int prd_old);
    rob_entry_t e = '0;
    e.ard         = arf_id_t'(ard);
    e.prd         = preg_id_t'(prd);
    e.prd_old     = preg_id_t'(prd_old);
    e.needprf2arf = 1'b1;
    return e;
  endfunction

  function automatic void model_reset();
    fq.delete();
    inflight.delete();
    for (int i = 32; i < 64; i++) fq.push_back(i);
    for (int i = 0; i < 32; i++) begin
      spec_map[i]   = i;
      commit_map[i] = i;
    end
  endfunction

  function automatic bit model_ready();
    int n = 0;
    for (int s = 0; s < RENAME_WIDTH; s++) begin
      if (di_i_valid[s] && di_i[s].rd_valid && di_i[s].rd != 0) n++;
    end
    return rstn && di_o_ready && !sq.valid && (n <= fq.size());
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input di_t s0, input di_t s1, input logic [1:0] v,
                               input rob_entry_t r0, input rob_entry_t r1,
                               input logic [1:0] rv, input logic sqv, input logic oready);
    @(posedge clk);
    #1;
    di_i[0]              = s0;
    di_i[1]              = s1;
    di_i_valid           = v;
    retire_entry_i[0]    = r0;
    retire_entry_i[1]    = r1;
    retire_entry_i_valid = rv;
    sq.valid             = sqv;
    di_o_ready           = oready;
  endtask

  task automatic idle();
    applyStimulus('0, '0, 2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic rename1(input di_t s0);
    applyStimulus(s0, '0, 2'b01, '0, '0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    applyStimulus(mk(1, 2, 3, 1), '0, 2'b01, '0, '0, 2'b00, 1'b0, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", int'(di_i_ready), 0);
    checkOutput("reset_valid", int'(di_o_valid), 0);
    idle();
    rstn = 1'b1;
  endtask

  // Per-cycle compare against the model, then advance the model on the edge
  initial begin : compare
    int  tmp[32];
    int  k;
    int  p;
    bit  er;
    forever begin
      @(negedge clk);
      er = model_ready();
      checkOutput("cyc_ready", int'(di_i_ready), int'(er));
      checkOutput("cyc_valid", int'(di_o_valid), int'(di_i_valid & {2{er}}));
      if (er) begin
        tmp = spec_map;
        k   = 0;
        for (int s = 0; s < RENAME_WIDTH; s++) begin
          if (di_i_valid[s]) begin
            checkOutput("cyc_prs1", int'(di_o[s].prs1), (di_i[s].rs1 == 0) ? 0 : tmp[di_i[s].rs1]);
            checkOutput("cyc_prs2", int'(di_o[s].prs2), (di_i[s].rs2 == 0) ? 0 : tmp[di_i[s].rs2]);
            checkOutput("cyc_prd_old", int'(di_o[s].prd_old), (di_i[s].rd == 0) ? 0 : tmp[di_i[s].rd]);
            checkOutput("cyc_renammed", int'({di_o[s].prs1_renammed, di_o[s].prs2_renammed}), 3);
            if (di_i[s].rd_valid && di_i[s].rd != 0 && k < fq.size()) begin
              checkOutput("cyc_prd", int'(di_o[s].prd), fq[k]);
              tmp[di_i[s].rd] = fq[k];
              k++;
            end else begin
              checkOutput("cyc_prd", int'(di_o[s].prd), 0);
            end
          end
        end
      end
      @(posedge clk);
      if (!rstn) begin
        model_reset();
      end else begin
        er = model_ready();
        if (er) begin
          for (int s = 0; s < RENAME_WIDTH; s++) begin
            if (di_i_valid[s] && di_i[s].rd_valid && di_i[s].rd != 0) begin
              p = fq.pop_front();
              inflight.push_back(p);
              spec_map[di_i[s].rd] = p;
            end
          end
        end
        for (int r = 0; r < RETIRE_WIDTH; r++) begin
          if (retire_entry_i_valid[r] && retire_entry_i[r].needprf2arf) begin
            commit_map[retire_entry_i[r].ard] = int'(retire_entry_i[r].prd);
            fq.push_back(int'(retire_entry_i[r].prd_old));
            if (inflight.size() > 0) void'(inflight.pop_front());
          end
        end
        if (sq.valid) begin
          spec_map = commit_map;
          fq = {inflight, fq};
          inflight.delete();
        end
      end
    end
  end

  // Directed scenarios with hand-computed expectations
  initial begin : stimulus
    rstn                 = 1'b0;
    di_i                 = '0;
    di_i_valid           = '0;
    di_o_ready           = 1'b1;
    retire_entry_i       = '0;
    retire_entry_i_valid = '0;
    sq.valid             = 1'b0;

    $display("[TB] single-slot rename after reset");
    do_reset();
    rename1(mk(1, 2, 3, 1));
    @(negedge clk);
    checkOutput("t1_ready", int'(di_i_ready), 1);
    checkOutput("t1_prs1", int'(di_o[0].prs1), 2);
    checkOutput("t1_prs2", int'(di_o[0].prs2), 3);
    checkOutput("t1_prd", int'(di_o[0].prd), 32);
    checkOutput("t1_prd_old", int'(di_o[0].prd_old), 1);

    $display("[TB] intra-group source bypass");
    do_reset();
    applyStimulus(mk(5, 6, 7, 1), mk(8, 5, 5, 1), 2'b11, '0, '0, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t2_s0_prd", int'(di_o[0].prd), 32);
    checkOutput("t2_s1_prs1", int'(di_o[1].prs1), 32);
    checkOutput("t2_s1_prs2", int'(di_o[1].prs2), 32);
    checkOutput("t2_s1_prd", int'(di_o[1].prd), 33);
    idle();
    @(negedge clk);
    checkOutput("t2_rmt5", int'(dut.spec_rmt[5]), 32);
    checkOutput("t2_rmt8", int'(dut.spec_rmt[8]), 33);

    $display("[TB] same destination in both slots");
    do_reset();
    applyStimulus(mk(4, 1, 2, 1), mk(4, 4, 3, 1), 2'b11, '0, '0, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t3_s0_prd", int'(di_o[0].prd), 32);
    checkOutput("t3_s0_prd_old", int'(di_o[0].prd_old), 4);
    checkOutput("t3_s1_prd", int'(di_o[1].prd), 33);
    checkOutput("t3_s1_prd_old", int'(di_o[1].prd_old), 32);
    checkOutput("t3_s1_prs1", int'(di_o[1].prs1), 32);
    idle();
    @(negedge clk);
    checkOutput("t3_rmt4", int'(dut.spec_rmt[4]), 33);

    $display("[TB] free list exhaustion and refill by retire");
    do_reset();
    for (int i = 0; i < 32; i++) rename1(mk((i % 31) + 1, 0, 0, 1));
    rename1(mk(5, 6, 7, 1));
    @(negedge clk);
    checkOutput("t4_stall_ready", int'(di_i_ready), 0);
    checkOutput("t4_stall_valid", int'(di_o_valid), 0);
    applyStimulus(mk(5, 6, 7, 1), '0, 2'b01, mkr(1, 32, 1), '0, 2'b01, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t4_no_bypass_ready", int'(di_i_ready), 0);
    rename1(mk(5, 6, 7, 1));
    @(negedge clk);
    checkOutput("t4_refill_ready", int'(di_i_ready), 1);
    checkOutput("t4_refill_prd", int'(di_o[0].prd), 1);

    $display("[TB] squash after partial retire");
    do_reset();
    applyStimulus(mk(1, 0, 0, 1), mk(2, 0, 0, 1), 2'b11, '0, '0, 2'b00, 1'b0, 1'b1);
    rename1(mk(3, 0, 0, 1));
    applyStimulus('0, '0, 2'b00, mkr(1, 32, 1), '0, 2'b01, 1'b0, 1'b1);
    applyStimulus('0, '0, 2'b00, '0, '0, 2'b00, 1'b1, 1'b1);
    rename1(mk(9, 1, 2, 1));
    @(negedge clk);
    checkOutput("t5_prs1", int'(di_o[0].prs1), 32);
    checkOutput("t5_prs2", int'(di_o[0].prs2), 2);
    checkOutput("t5_prd", int'(di_o[0].prd), 33);
    checkOutput("t5_prd_old", int'(di_o[0].prd_old), 9);

    $display("[TB] x0 destination, backpressure, retire with squash");
    do_reset();
    rename1(mk(0, 0, 5, 1));
    @(negedge clk);
    checkOutput("t6_x0_ready", int'(di_i_ready), 1);
    checkOutput("t6_x0_prd", int'(di_o[0].prd), 0);
    checkOutput("t6_x0_prs1", int'(di_o[0].prs1), 0);
    checkOutput("t6_x0_prs2", int'(di_o[0].prs2), 5);
    applyStimulus(mk(1, 2, 0, 1), '0, 2'b01, '0, '0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_bp_ready", int'(di_i_ready), 0);
    rename1(mk(1, 2, 0, 1));
    @(negedge clk);
    checkOutput("t6_head_kept_prd", int'(di_o[0].prd), 32);
    rename1(mk(3, 0, 0, 1));
    applyStimulus(mk(7, 0, 0, 1), '0, 2'b01, mkr(1, 32, 1), '0, 2'b01, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t6_squash_ready", int'(di_i_ready), 0);
    rename1(mk(10, 1, 3, 1));
    @(negedge clk);
    checkOutput("t6_after_prs1", int'(di_o[0].prs1), 32);
    checkOutput("t6_after_prs2", int'(di_o[0].prs2), 3);
    checkOutput("t6_after_prd", int'(di_o[0].prd), 33);

    idle();
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/rename_fl.md
Name: rename_fl

Overview:
- N-wide register renamer replacing the counter-allocator renamer.
- Sits between decode and dispatch.
- Keeps a speculative RMT, a committed RMT and a circular free list of pregs.
- Renames up to WIDTH instructions per cycle with intra-group dependency bypass, frees pregs at retire, and recovers exactly on squash by restoring state from the committed RMT and committed free-list head.

Parameters:
- WIDTH, 2, rename slots per cycle.
- RWIDTH, 2, retire slots per cycle.
- ARFSIZE, 32, architectural registers (from package C).
- PRFSIZE, 64, physical registers; power of 2; must exceed ARFSIZE+WIDTH.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- di_i  in  WIDTH x di_t  instruction group, slot 0 oldest.
- di_i_valid  in  WIDTH  per-slot valid; valid slots must be contiguous from slot 0.
- di_i_ready  out  1  group accepted this cycle.
- di_o  out  WIDTH x di_t  renamed group.
- di_o_valid  out  WIDTH  per-slot valid.
- di_o_ready  in  1  downstream accepts the whole group.
- retire_entry_i  in  RWIDTH x rob_entry_t  retiring entries, slot 0 oldest.
- retire_entry_i_valid  in  RWIDTH  per-slot valid.
- squash_io  squash_if.slave  -  squash_io.valid flushes all speculative state.

Behaviour:
- Reset, in the cycle after rstn=0 is sampled:
  - spec_rmt[i] = commit_rmt[i] = i for all i.
  - Free list holds ARFSIZE..PRFSIZE-1 in order.
  - head = commit_head = 0, tail = PRFSIZE-ARFSIZE.
  - Pointers are PREG_ID_BITS+1 wide so full and empty are distinguishable.
- Outputs are combinational from state and inputs (0-cycle latency); state updates on the next posedge.
  - di_o_valid = di_i_valid & {WIDTH{di_i_ready}}.
  - During reset, di_o_valid = 0 and di_i_ready = 0.
- A slot needs allocation iff valid && si.rd_valid && si.rd != 0. Let need = popcount of such slots; free = tail - head.
- di_i_ready = di_o_ready && !squash_io.valid && (need <= free). All-or-nothing: no partial groups.
- Allocation:
  - The k-th allocating slot receives freelist[head+k].
  - On accept, head += need (wraps modulo PRFSIZE).
- Source read for slot s, operand rsX:
  - Take prd of the youngest slot j<s with allocation and rd==rsX; otherwise spec_rmt[rsX].
  - rs==0 always yields preg 0.
  - prs1_renammed and prs2_renammed are always 1.
- prd_old for slot s (new di_t field) = the mapping of rd before slot s, using the same bypass rule. di_o.prd = allocated preg (0 when no allocation).
- Speculative RMT update on accept: spec_rmt[rd] <= prd; if several slots share rd, the youngest wins.
- Retire, per valid slot with needprf2arf, processed in slot order:
  - commit_rmt[ard] <= prd; youngest same-ard slot wins.
  - freelist[tail] <= prd_old; tail++.
  - commit_head++.
  - Freed pregs become allocatable the next cycle (no same-cycle bypass).
- Squash (squash_io.valid=1):
  - Rename blocked: di_i_ready = 0.
  - Retires in the same cycle are still applied.
  - spec_rmt <= commit_rmt as updated by this cycle's retires; head <= the updated commit_head; tail keeps its retire update.
- Invariant: free never exceeds PRFSIZE-ARFSIZE. Assert on overflow, and assert on any retire when commit_head == head.
- Log the RMT each negedge via `LOG(REN, ...).

Decomposition:
- Package C additions:
  - prd_old field in di_t and rob_entry_t.
  - FL_PTR_BITS = PREG_ID_BITS+1.
  - fl_ptr_t typedef.
  - RENAME_WIDTH and RETIRE_WIDTH constants.
- One sub-module, rename_freelist: circular preg FIFO with multi-pop head, multi-push tail, commit_head and squash restore.
- RMT logic and intra-group bypass stay in rename_fl.

Test Plan (WIDTH=2, ARFSIZE=32, PRFSIZE=64):
- Reset, then slot0 add x1<-x2,x3 -> prs1=2, prs2=3, prd=32, prd_old=1, di_i_ready=1.
- Group {x5<-x6,x7 ; x8<-x5,x5} -> slot1 prs1=prs2=32, slot1 prd=33; spec_rmt[5]=32, spec_rmt[8]=33.
- Group {x4<-.. ; x4<-..} -> slot0 prd=32 (prd_old=4), slot1 prd=33 (prd_old=32); spec_rmt[4]=33.
- Rename 32 single-rd instructions with no retire -> the 33rd stalls (di_i_ready=0, di_o_valid=0). Retire one entry (prd_old=1) -> accepted next cycle with prd=1.
- Allocate 32, 33, 34 to x1, x2, x3; retire only the x1 entry; squash -> x1 maps to 32, x2 maps to 2; the next rename with rd gets prd=33.
- rd=x0 with rs1=x0 -> no allocation, head unchanged, prd=0, prs1=0. Retire and squash in the same cycle -> the retired mapping survives in spec_rmt.
